// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter between the WB stage and the mul/div unit.
// It also acts as the scoreboard for in-flight mul/div destinations.
module reg_write_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        iss_md,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_we,
  output logic        sb_stall,
  output logic        force_bubble,
  output logic        sb_err,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData
);

  localparam logic [3:0] StarveLim = 4'(STARVE_MAX - 1);

  logic        r_hold_valid;
  logic [4:0]  r_hold_rd;
  logic [31:0] r_hold_data;
  logic [31:0] r_busy;
  logic [3:0]  r_starve_cnt;

  logic        w_accept;
  logic        w_sel_hold;
  logic        w_sel_md;
  logic        w_grant;
  logic        w_load_hold;
  logic [4:0]  w_sel_rd;
  logic [31:0] w_sel_data;
  logic [31:0] w_busy_d;
  logic [31:0] w_busy_eff;
  logic        w_starve;
  logic [3:0]  w_starve_d;

  always_comb begin
    w_accept    = md_valid && !r_hold_valid;
    w_sel_hold  = !wb_we && r_hold_valid;
    w_sel_md    = !wb_we && w_accept;
    w_grant     = wb_we || w_sel_hold || w_sel_md;
    w_load_hold = w_accept && wb_we;

    w_sel_rd   = 5'd0;
    w_sel_data = 32'd0;
    if (wb_we) begin
      w_sel_rd   = wb_rd;
      w_sel_data = wb_data;
    end else if (r_hold_valid) begin
      w_sel_rd   = r_hold_rd;
      w_sel_data = r_hold_data;
    end else if (w_accept) begin
      w_sel_rd   = md_rd;
      w_sel_data = md_data;
    end

    // Clear on mul/div emit first so a same-cycle reissue of that register wins.
    w_busy_d = r_busy;
    if (w_sel_hold || w_sel_md) w_busy_d[w_sel_rd] = 1'b0;
    if (iss_md && iss_rd != 5'd0) w_busy_d[iss_rd] = 1'b1;

    w_starve   = r_hold_valid && wb_we;
    w_starve_d = 4'd0;
    if (w_starve) w_starve_d = (r_starve_cnt == 4'hf) ? 4'hf : r_starve_cnt + 4'd1;
  end

  assign md_ready   = !r_hold_valid;
  assign w_busy_eff = {r_busy[31:1], 1'b0};
  assign sb_stall   = w_busy_eff[id_rs] | w_busy_eff[id_rt] | (id_we & w_busy_eff[id_rd]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite     <= 1'b0;
      writeReg     <= 5'd0;
      writeData    <= 32'd0;
      r_hold_valid <= 1'b0;
      r_hold_rd    <= 5'd0;
      r_hold_data  <= 32'd0;
      r_busy       <= 32'd0;
      r_starve_cnt <= 4'd0;
      sb_err       <= 1'b0;
      force_bubble <= 1'b0;
    end else begin
      regWrite <= w_grant && (w_sel_rd != 5'd0);
      if (w_grant) begin
        writeReg  <= w_sel_rd;
        writeData <= w_sel_data;
      end
      if (w_load_hold) begin
        r_hold_valid <= 1'b1;
        r_hold_rd    <= md_rd;
        r_hold_data  <= md_data;
      end else if (w_sel_hold) begin
        r_hold_valid <= 1'b0;
      end
      r_busy       <= w_busy_d;
      r_starve_cnt <= w_starve_d;
      force_bubble <= w_starve && (w_starve_d >= StarveLim);
      if (iss_md && r_busy[iss_rd]) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: vector table plus hand-written
// sequences for starvation, sticky error and mid-hold reset.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_we, md_valid, iss_md, id_we;
  logic [4:0]  wb_rd, md_rd, iss_rd, id_rs, id_rt, id_rd;
  logic [31:0] wb_data, md_data;
  logic        md_ready, sb_stall, force_bubble, sb_err, regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .iss_md(iss_md), .iss_rd(iss_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_we(id_we),
    .sb_stall(sb_stall), .force_bubble(force_bubble), .sb_err(sb_err),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
  );

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        iss_md;
    logic [4:0]  iss_rd;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        exp_rdy;    // before edge
    logic        exp_stall;  // before edge
    logic        exp_rw;     // after edge
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    iss_md = 0; iss_rd = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_we = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic im, input logic [4:0] ird,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic iwe, input logic erdy, input logic est,
                              input logic erw, input logic [4:0] ewr, input logic [31:0] ewd);
    vec_t v;
    v.wb_we = we; v.wb_rd = wrd; v.wb_data = wd;
    v.md_valid = mv; v.md_rd = mrd; v.md_data = md;
    v.iss_md = im; v.iss_rd = ird;
    v.id_rs = rs; v.id_rt = rt; v.id_rd = rd; v.id_we = iwe;
    v.exp_rdy = erdy; v.exp_stall = est; v.exp_rw = erw; v.exp_wr = ewr; v.exp_wd = ewd;
    return v;
  endfunction

  initial begin
    //            we rd  data     mv rd  data       im ird rs  rt  rd  iwe rdy st rw wr  wd
    vecs[0]  = mk(1, 5, 32'h7,    0, 0, 0,          0, 0,  0,  0,  0,  0,  1, 0, 1, 5, 32'h7);
    vecs[1]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  0,  0,  0,  0,  1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 3, 32'h33,   1, 8, 32'hABCD,   0, 0,  0,  0,  0,  0,  1, 0, 1, 3, 32'h33);
    vecs[3]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  0,  0,  0,  0,  0, 0, 1, 8, 32'hABCD);
    vecs[4]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  0,  0,  0,  0,  1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0,        0, 0, 0,          1, 9,  0,  0,  0,  0,  1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0,        1, 9, 32'h99,     0, 0,  9,  0,  0,  0,  1, 1, 1, 9, 32'h99);
    vecs[7]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  9,  0,  0,  0,  1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0,        0, 0, 0,          1, 10, 0,  0,  0,  0,  1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0,        0, 0, 0,          0, 0,  0,  0,  10, 0,  1, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0,        1, 10, 32'h1,     0, 0,  0,  10, 10, 1,  1, 1, 1, 10, 32'h1);
    vecs[11] = mk(0, 0, 0,        0, 0, 0,          0, 0,  0,  10, 10, 1,  1, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0,        1, 0, 32'h5,      0, 0,  0,  0,  0,  0,  1, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0,        0, 0, 0,          1, 0,  0,  0,  0,  0,  1, 0, 0, 0, 0);

    idle_inputs();
    #12;
    check("reset_regWrite", regWrite, 0);
    check("reset_writeReg", writeReg, 0);
    check("reset_writeData", writeData, 0);
    check("reset_md_ready", md_ready, 1);
    check("reset_fb", force_bubble, 0);
    check("reset_err", sb_err, 0);
    rst = 1;
    tick();

    foreach (vecs[i]) begin
      wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      md_valid = vecs[i].md_valid; md_rd = vecs[i].md_rd; md_data = vecs[i].md_data;
      iss_md = vecs[i].iss_md; iss_rd = vecs[i].iss_rd;
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; id_rd = vecs[i].id_rd;
      id_we = vecs[i].id_we;
      #1;
      check($sformatf("v%0d_md_ready", i), md_ready, vecs[i].exp_rdy);
      check($sformatf("v%0d_sb_stall", i), sb_stall, vecs[i].exp_stall);
      tick();
      check($sformatf("v%0d_regWrite", i), regWrite, vecs[i].exp_rw);
      if (vecs[i].exp_rw) begin
        check($sformatf("v%0d_writeReg", i), writeReg, vecs[i].exp_wr);
        check($sformatf("v%0d_writeData", i), writeData, vecs[i].exp_wd);
      end
      check($sformatf("v%0d_sb_err", i), sb_err, 0);
    end
    // After the $0 issue, $0 as a source must still not stall.
    idle_inputs();
    #1;
    check("r0_no_stall", sb_stall, 0);

    // Starvation: hold loaded, WB keeps the port busy for three cycles.
    wb_we = 1; wb_rd = 1; wb_data = 32'h11; md_valid = 1; md_rd = 12; md_data = 32'hC;
    tick();
    check("st_load_wr", writeReg, 1);
    check("st_load_fb", force_bubble, 0);
    md_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      wb_rd = 5'(k + 1); wb_data = k;
      #1;
      check($sformatf("st_c%0d_md_ready", k), md_ready, 0);
      tick();
      check($sformatf("st_c%0d_fb", k), force_bubble, (k == 3));
      check($sformatf("st_c%0d_wr", k), writeReg, 5'(k + 1));
    end
    wb_we = 0;
    tick();
    check("st_drain_rw", regWrite, 1);
    check("st_drain_wr", writeReg, 12);
    check("st_drain_wd", writeData, 32'hC);
    check("st_drain_fb", force_bubble, 0);
    check("st_drain_rdy", md_ready, 1);
    tick();
    check("st_after_fb", force_bubble, 0);

    // Double issue to r4 sets a sticky error.
    iss_md = 1; iss_rd = 4;
    tick();
    check("err_first", sb_err, 0);
    tick();
    check("err_second", sb_err, 1);
    iss_md = 0;
    tick();
    tick();
    check("err_sticky", sb_err, 1);

    // Reset in the middle of a pending hold.
    iss_md = 1; iss_rd = 14;
    wb_we = 1; wb_rd = 2; wb_data = 32'h22; md_valid = 1; md_rd = 13; md_data = 32'hD;
    tick();
    idle_inputs();
    check("rh_pre_rdy", md_ready, 0);
    rst = 0;
    #1;
    check("rh_rw", regWrite, 0);
    check("rh_wr", writeReg, 0);
    check("rh_wd", writeData, 0);
    check("rh_rdy", md_ready, 1);
    check("rh_err", sb_err, 0);
    check("rh_fb", force_bubble, 0);
    #3;
    rst = 1;
    id_rs = 14;
    tick();
    check("rh_post_rw", regWrite, 0);
    check("rh_busy_lost", sb_stall, 0);
    tick();
    check("rh_post_rw2", regWrite, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
